// File: rtl/agc_shift_ctrl_pkg.sv
// Shared types and widths for the AGC shift controller.
package agc_shift_ctrl_pkg;

  localparam int unsigned SHIFT_W = 5;
  localparam int unsigned OUT_W   = 16;
  localparam int unsigned MAG_W   = 31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_EVAL  = 2'd2,
    ST_APPLY = 2'd3
  } agc_state_e;

  // Ones' complement magnitude: no overflow for the most negative sample.
  function automatic logic [MAG_W-1:0] mag31(input logic [31:0] s);
    return s[31] ? ~s[30:0] : s[30:0];
  endfunction

endpackage

// File: rtl/agc_shift_ctrl_if.sv
// Sample stream, control and shift-output bundle of the AGC controller.
interface agc_shift_ctrl_if;
  import agc_shift_ctrl_pkg::*;

  logic               enable;
  logic               manual_en;
  logic [SHIFT_W-1:0] manual_shift;
  logic [31:0]        din;
  logic               din_valid;
  logic [OUT_W-1:0]   scaled_coeff;
  logic               shift_upd;
  logic [SHIFT_W-1:0] peak_lz;
  logic               clip_flag;

  modport master (
    output enable, manual_en, manual_shift, din, din_valid,
    input  scaled_coeff, shift_upd, peak_lz, clip_flag
  );

  modport slave (
    input  enable, manual_en, manual_shift, din, din_valid,
    output scaled_coeff, shift_upd, peak_lz, clip_flag
  );

endinterface

// File: rtl/agc_shift_ctrl_lzc31.sv
// Combinational 31-bit leading-zero counter; all-zero input gives 31.
module agc_shift_ctrl_lzc31
  import agc_shift_ctrl_pkg::*;
(
  input  logic [MAG_W-1:0]   v_i,
  output logic [SHIFT_W-1:0] lz_o
);

  // Ascending scan: the highest set bit is the last one to win.
  always_comb begin
    lz_o = SHIFT_W'(MAG_W);
    for (int i = 0; i < int'(MAG_W); i++) begin
      if (v_i[i]) lz_o = SHIFT_W'(int'(MAG_W) - 1 - i);
    end
  end

endmodule

// File: rtl/agc_shift_ctrl.sv
// Peak-tracking AGC that picks the largest non-clipping left shift per window
// and drives the 32->16 scaling shifter; fast attack, stepped release.
module agc_shift_ctrl
  import agc_shift_ctrl_pkg::*;
#(
  parameter int unsigned WIN_LOG2     = 10,
  parameter int unsigned HEADROOM     = 1,
  parameter int unsigned MAX_SHIFT    = 16,
  parameter int unsigned RELEASE_WINS = 4
) (
  input  logic             clk,
  input  logic             rst,
  agc_shift_ctrl_if.slave  bus
);

  localparam int unsigned        REL_W   = (RELEASE_WINS < 2) ? 1 : $clog2(RELEASE_WINS + 1);
  localparam logic [REL_W-1:0]   REL_MAX = REL_W'(RELEASE_WINS);
  localparam logic [SHIFT_W-1:0] MAX_C   = SHIFT_W'(MAX_SHIFT);

  agc_state_e          state_q, state_d;
  logic [WIN_LOG2-1:0] cnt_q, cnt_d;
  logic [MAG_W-1:0]    peak_q, peak_d;
  logic [MAG_W-1:0]    hold_q, hold_d;
  logic [REL_W-1:0]    rel_q, rel_d;
  logic [SHIFT_W-1:0]  cur_q, cur_d;
  logic [SHIFT_W-1:0]  lz_q, lz_d;
  logic [SHIFT_W-1:0]  tgt_q, tgt_d;
  logic                upd_q, upd_d;
  logic                clip_q, clip_d;

  logic [MAG_W-1:0]    mag_c;
  logic [MAG_W-1:0]    peak_max_c;
  logic [SHIFT_W-1:0]  lz_c;
  logic [SHIFT_W-1:0]  tgt_c;
  logic [SHIFT_W-1:0]  man_c;
  logic [REL_W-1:0]    rel_inc_c;
  logic                win_end_c;
  int                  tgt_raw_c;

  agc_shift_ctrl_lzc31 u_lzc31 (
    .v_i  (hold_q),
    .lz_o (lz_c)
  );

  assign mag_c      = mag31(bus.din);
  assign peak_max_c = (mag_c > peak_q) ? mag_c : peak_q;
  assign win_end_c  = bus.din_valid && (cnt_q == '1);
  assign man_c      = (bus.manual_shift > MAX_C) ? MAX_C : bus.manual_shift;
  assign rel_inc_c  = rel_q + REL_W'(1);

  // Headroom subtraction is signed so small lz clamps to zero instead of wrapping.
  always_comb begin
    tgt_raw_c = int'(lz_c) - int'(HEADROOM);
    if (tgt_raw_c < 0)                   tgt_c = '0;
    else if (tgt_raw_c > int'(MAX_SHIFT)) tgt_c = MAX_C;
    else                                  tgt_c = SHIFT_W'(tgt_raw_c);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    peak_d  = peak_q;
    hold_d  = hold_q;
    rel_d   = rel_q;
    cur_d   = cur_q;
    lz_d    = lz_q;
    tgt_d   = tgt_q;
    upd_d   = 1'b0;
    clip_d  = 1'b0;

    if (!bus.enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      peak_d  = '0;
      rel_d   = '0;
    end else begin
      // Accumulation never stalls, so the next window overlaps EVAL/APPLY.
      if (bus.din_valid) begin
        if (win_end_c) begin
          hold_d = peak_max_c;
          peak_d = '0;
          cnt_d  = '0;
        end else begin
          peak_d = peak_max_c;
          cnt_d  = cnt_q + WIN_LOG2'(1);
        end
      end

      case (state_q)
        ST_IDLE: state_d = ST_RUN;
        ST_RUN:  if (win_end_c) state_d = ST_EVAL;
        ST_EVAL: begin
          lz_d    = lz_c;
          tgt_d   = tgt_c;
          state_d = ST_APPLY;
        end
        ST_APPLY: begin
          state_d = ST_RUN;
          if (!bus.manual_en) begin
            if (tgt_q < cur_q) begin
              cur_d  = tgt_q;
              clip_d = 1'b1;
              rel_d  = '0;
            end else if (tgt_q > cur_q) begin
              if (rel_inc_c == REL_MAX) begin
                cur_d = cur_q + SHIFT_W'(1);
                rel_d = '0;
              end else begin
                rel_d = rel_inc_c;
              end
            end else begin
              rel_d = '0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (bus.manual_en) begin
        cur_d = man_c;
        rel_d = '0;
      end
      upd_d = (cur_d != cur_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      peak_q  <= '0;
      hold_q  <= '0;
      rel_q   <= '0;
      cur_q   <= '0;
      lz_q    <= '0;
      tgt_q   <= '0;
      upd_q   <= 1'b0;
      clip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      peak_q  <= peak_d;
      hold_q  <= hold_d;
      rel_q   <= rel_d;
      cur_q   <= cur_d;
      lz_q    <= lz_d;
      tgt_q   <= tgt_d;
      upd_q   <= upd_d;
      clip_q  <= clip_d;
    end
  end

  assign bus.scaled_coeff = {{(OUT_W - SHIFT_W){1'b0}}, cur_q};
  assign bus.shift_upd    = upd_q;
  assign bus.peak_lz      = lz_q;
  assign bus.clip_flag    = clip_q;

endmodule

// File: tb/tb_agc_shift_ctrl.sv
// Directed bench for agc_shift_ctrl: a behavioural window model pushes the
// expected per-window result, checked two cycles after the window-end edge.
module tb_agc_shift_ctrl;

  localparam int WIN = 16;
  localparam int HR  = 1;
  localparam int MAXS = 16;
  localparam int RELW = 4;

  typedef struct {
    int         due;
    logic [4:0] lz;
    logic [4:0] cur;
    logic       clip;
    logic       upd;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  agc_shift_ctrl_if bus ();

  agc_shift_ctrl #(
    .WIN_LOG2     (4),
    .HEADROOM     (HR),
    .MAX_SHIFT    (MAXS),
    .RELEASE_WINS (RELW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sb_q[$];
  logic pend_end = 1'b0;

  int         m_cnt  = 0;
  logic [30:0] m_peak = '0;
  int         m_cur  = 0;
  int         m_rel  = 0;
  int         m_lz   = 0;
  bit         m_man  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int bench_lz(input logic [30:0] p);
    for (int i = 30; i >= 0; i--) if (p[i]) return 30 - i;
    return 31;
  endfunction

  // Behavioural window model: called for every accepted valid sample.
  task automatic model_sample(input logic [31:0] d);
    logic [30:0] m;
    int          t;
    exp_t        e;
    m = d[31] ? ~d[30:0] : d[30:0];
    if (m > m_peak) m_peak = m;
    if (m_cnt == WIN - 1) begin
      m_lz = bench_lz(m_peak);
      t = m_lz - HR;
      if (t < 0) t = 0;
      if (t > MAXS) t = MAXS;
      e.clip = 1'b0;
      e.upd  = 1'b0;
      if (m_man) begin
        m_rel = 0;
      end else if (t < m_cur) begin
        m_cur = t; m_rel = 0; e.clip = 1'b1; e.upd = 1'b1;
      end else if (t > m_cur) begin
        m_rel++;
        if (m_rel == RELW) begin
          m_cur++; m_rel = 0; e.upd = 1'b1;
        end
      end else begin
        m_rel = 0;
      end
      e.due = cyc + 3;
      e.lz  = 5'(m_lz);
      e.cur = 5'(m_cur);
      sb_q.push_back(e);
      m_peak = '0;
      m_cnt  = 0;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic drive(input logic [31:0] d, input logic v);
    @(negedge clk);
    bus.din       = d;
    bus.din_valid = v;
    if (v && bus.enable) model_sample(d);
  endtask

  task automatic window(input logic [31:0] base, input logic [31:0] spike, input int pos);
    for (int i = 0; i < WIN; i++) drive((i == pos) ? spike : base, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(32'h0, 1'b0);
  endtask

  task automatic set_manual(input logic en, input logic [4:0] sh);
    int   nv;
    logic exp_upd;
    @(negedge clk);
    bus.din_valid    = 1'b0;
    bus.manual_en    = en;
    bus.manual_shift = sh;
    exp_upd = 1'b0;
    if (en) begin
      nv = (int'(sh) > MAXS) ? MAXS : int'(sh);
      exp_upd = (nv != m_cur);
      m_cur = nv;
      m_rel = 0;
    end
    m_man = en;
    @(negedge clk);
    check("manual_coeff", 32'(bus.scaled_coeff), 32'(m_cur));
    check("manual_upd", 32'(bus.shift_upd), 32'(exp_upd));
  endtask

  // Scoreboard consumer: compares at E0+2 and checks the pulses end one cycle later.
  always @(negedge clk) begin
    if (pend_end) begin
      check("upd_width", 32'(bus.shift_upd), 32'h0);
      check("clip_width", 32'(bus.clip_flag), 32'h0);
    end
    pend_end <= 1'b0;
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      check("peak_lz", 32'(bus.peak_lz), 32'(sb_q[0].lz));
      check("scaled_coeff", 32'(bus.scaled_coeff), 32'(sb_q[0].cur));
      check("clip_flag", 32'(bus.clip_flag), 32'(sb_q[0].clip));
      check("shift_upd", 32'(bus.shift_upd), 32'(sb_q[0].upd));
      sb_q.delete(0);
      pend_end <= 1'b1;
    end
  end

  initial begin
    rst              = 1'b1;
    bus.enable       = 1'b0;
    bus.manual_en    = 1'b0;
    bus.manual_shift = 5'd0;
    bus.din          = 32'h0;
    bus.din_valid    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_coeff", 32'(bus.scaled_coeff), 32'h0);
    check("rst_upd", 32'(bus.shift_upd), 32'h0);
    check("rst_lz", 32'(bus.peak_lz), 32'h0);
    check("rst_clip", 32'(bus.clip_flag), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    bus.enable = 1'b1;

    // Quiet signal: stepped release from 0 to the clamp.
    for (int w = 0; w < 64; w++) window(32'h0000_1000, 32'h0, -1);
    idle(3);
    check("release_to_max", 32'(bus.scaled_coeff), 32'd16);

    // Attack from a single large sample, then full-scale negative, then -1.
    window(32'h0, 32'h0100_0000, 5);
    idle(3);
    window(32'h0, 32'h8000_0000, 9);
    idle(3);
    window(32'hFFFF_FFFF, 32'h0, -1);
    idle(3);

    // Manual override clamps, blocks attack, and hands its value back.
    set_manual(1'b1, 5'd20);
    window(32'h0000_1000, 32'h0, -1);
    window(32'h0, 32'h0100_0000, 3);
    idle(3);
    set_manual(1'b0, 5'd20);
    window(32'h0, 32'h0100_0000, 0);
    idle(3);

    // Gated valid: invalid cycles carry a full-scale value that must be ignored.
    for (int i = 0; i < WIN; i++) begin
      drive(32'h0000_0100, 1'b1);
      drive(32'h7FFF_FFFF, 1'b0);
      drive(32'h7FFF_FFFF, 1'b0);
    end
    idle(3);

    // Enable drop mid-window discards the partial peak and release count.
    for (int i = 0; i < 8; i++) drive((i == 2) ? 32'h4000_0000 : 32'h0000_1000, 1'b1);
    @(negedge clk);
    bus.enable    = 1'b0;
    bus.din       = 32'h4000_0000;
    bus.din_valid = 1'b1;
    m_cnt = 0; m_peak = '0; m_rel = 0;
    @(negedge clk);
    check("dis_coeff_hold", 32'(bus.scaled_coeff), 32'(m_cur));
    check("dis_lz_hold", 32'(bus.peak_lz), 32'(m_lz));
    bus.enable    = 1'b1;
    bus.din_valid = 1'b0;
    for (int w = 0; w < 4; w++) window(32'h0000_1000, 32'h0, -1);
    idle(3);

    // Asynchronous reset mid-window.
    for (int i = 0; i < 8; i++) drive(32'h4000_0000, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_coeff", 32'(bus.scaled_coeff), 32'h0);
    check("arst_upd", 32'(bus.shift_upd), 32'h0);
    check("arst_lz", 32'(bus.peak_lz), 32'h0);
    check("arst_clip", 32'(bus.clip_flag), 32'h0);
    m_cnt = 0; m_peak = '0; m_rel = 0; m_cur = 0; m_lz = 0;
    @(negedge clk);
    rst = 1'b0;
    bus.din_valid = 1'b0;
    window(32'h0000_1000, 32'h0, -1);
    idle(4);

    check("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
